// File: rtl/hdmi_pixel_fetch.sv
// Prefetches RGB565 pixels ahead of the HDMI transmitter's scan address and
// drives them as expanded 8-bit RGB, flushing and refetching on underrun or frame slip.
module hdmi_pixel_fetch #(
  parameter int          FRAME_PIXELS    = 307200,
  parameter int          FIFO_DEPTH      = 16,
  parameter int          MAX_OUTSTANDING = 8,
  parameter logic [23:0] UNDERRUN_RGB    = 24'hFF00FF
) (
  input  logic                        clk_low,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [20:0]                 addr,
  output logic                        mem_req,
  output logic [20:0]                 mem_addr,
  input  logic                        mem_gnt,
  input  logic                        mem_rvalid,
  input  logic [15:0]                 mem_rdata,
  output logic [7:0]                  red,
  output logic [7:0]                  green,
  output logic [7:0]                  blue,
  output logic                        underrun,
  output logic                        resync,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((LVL_W > OUT_W) ? LVL_W : OUT_W) + 1;
  localparam logic [20:0]      LAST_IDX = 21'(FRAME_PIXELS - 1);
  localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(FIFO_DEPTH);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_e;

  state_e           state_q, state_d;
  logic [20:0]      fetch_idx_q, fetch_idx_d;
  logic [20:0]      cons_idx_q, cons_idx_d;
  logic [20:0]      addr_q;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [15:0]      fifo_q [FIFO_DEPTH];
  logic [23:0]      rgb_q, rgb_d;
  logic             underrun_q, underrun_d;
  logic             resync_q, resync_d;

  logic        step, wrap, fifo_empty, misalign, underrun_evt;
  logic        grant, rsp, push, pop;
  logic [20:0] cons_inc;
  logic [15:0] head;

  // Credit covers both stored and in-flight pixels, so a response always finds room.
  assign mem_req = (state_q == FETCH) && enable &&
                   ((SUM_W'(level_q) + SUM_W'(outst_q)) < DEPTH_S) &&
                   (outst_q < MAX_OUT);
  assign grant = mem_req && mem_gnt;
  assign rsp   = mem_rvalid && (outst_q != '0);
  assign push  = rsp && (state_q != FLUSH);

  assign fifo_empty   = (level_q == '0);
  assign step         = (addr != addr_q) && (addr != '0);
  assign wrap         = (addr == '0) && (addr_q != '0);
  assign pop          = step && !fifo_empty;
  assign misalign     = wrap && (cons_idx_q != '0);
  assign underrun_evt = step && fifo_empty;
  assign cons_inc     = (cons_idx_q == LAST_IDX) ? '0 : cons_idx_q + 21'd1;
  assign head         = fifo_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    fetch_idx_d = fetch_idx_q;
    cons_idx_d  = cons_idx_q;
    outst_d     = outst_q + OUT_W'(grant) - OUT_W'(rsp);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    underrun_d  = underrun_q;
    resync_d    = 1'b0;
    rgb_d       = UNDERRUN_RGB;

    if (state_q != FLUSH && !fifo_empty)
      rgb_d = {head[15:11], head[15:13], head[10:5], head[10:9], head[4:0], head[4:2]};
    if (grant)
      fetch_idx_d = (fetch_idx_q == LAST_IDX) ? '0 : fetch_idx_q + 21'd1;
    if (push)
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (step)
      cons_idx_d = cons_inc;

    case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   if (!enable && outst_q == '0) state_d = IDLE;
      FLUSH:   if (outst_q == '0) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    // A frame slip restarts at pixel 0; an underrun restarts at the pixel now on screen.
    if (misalign) begin
      state_d     = FLUSH;
      cons_idx_d  = '0;
      fetch_idx_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      resync_d    = 1'b1;
    end else if (underrun_evt) begin
      state_d     = FLUSH;
      fetch_idx_d = cons_inc;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      underrun_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_low or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fetch_idx_q <= '0;
      cons_idx_q  <= '0;
      addr_q      <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rgb_q       <= UNDERRUN_RGB;
      underrun_q  <= 1'b0;
      resync_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      fetch_idx_q <= fetch_idx_d;
      cons_idx_q  <= cons_idx_d;
      addr_q      <= addr;
      outst_q     <= outst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rgb_q       <= rgb_d;
      underrun_q  <= underrun_d;
      resync_q    <= resync_d;
      if (push) fifo_q[wr_ptr_q] <= mem_rdata;
    end
  end

  assign mem_addr   = fetch_idx_q;
  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign underrun   = underrun_q;
  assign resync     = resync_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_hdmi_pixel_fetch.sv
// Directed bench for hdmi_pixel_fetch with a queue-based pixel model,
// a fixed-latency in-order memory and a short frame so full-frame wraps stay fast.
module tb_hdmi_pixel_fetch;
  localparam int FRAME  = 1200;
  localparam int DEPTH  = 16;
  localparam int MAXOUT = 8;

  logic        clk_low = 1'b0;
  logic        reset, enable, mem_req, mem_gnt, mem_rvalid, underrun, resync;
  logic [20:0] addr, mem_addr;
  logic [15:0] mem_rdata;
  logic [7:0]  red, green, blue;
  logic [4:0]  fifo_level;
  logic [23:0] rgbOut;

  int compared   = 0;
  int mismatched = 0;

  hdmi_pixel_fetch #(
    .FRAME_PIXELS(FRAME), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXOUT), .UNDERRUN_RGB(24'hFF00FF)
  ) dut (
    .clk_low(clk_low), .reset(reset), .enable(enable), .addr(addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .red(red), .green(green), .blue(blue),
    .underrun(underrun), .resync(resync), .fifo_level(fifo_level)
  );

  assign rgbOut = {red, green, blue};
  always #5 clk_low = ~clk_low;

  typedef enum {M_IDLE, M_FETCH, M_FLUSH} mode_e;
  mode_e       mMode;
  logic [15:0] mFifo[$];
  int          mOut, mFetch, mCons, mPrevAddr;
  logic [23:0] mRgb;
  logic        mUnderrun, mResync;

  int          memDue[$];
  logic [15:0] memData[$];
  bit          memHold;
  int          cyc;
  logic        smpReq;
  logic [20:0] smpAddr;
  int          grants;
  int          lastGrantAddr;
  bit          wrapSeen;

  function automatic logic [15:0] pixOf(input int idx);
    case (idx)
      0:       return 16'hF800;
      1:       return 16'h07E0;
      2:       return 16'h001F;
      default: return 16'(idx * 40503 + 123);
    endcase
  endfunction

  function automatic logic [23:0] expand(input logic [15:0] p);
    int r, g, b;
    r = int'(p[15:11]);
    g = int'(p[10:5]);
    b = int'(p[4:0]);
    return {8'((r << 3) | (r >> 2)), 8'((g << 2) | (g >> 4)), 8'((b << 3) | (b >> 2))};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mMode = M_IDLE; mFifo.delete(); mOut = 0; mFetch = 0; mCons = 0; mPrevAddr = 0;
    mRgb = 24'hFF00FF; mUnderrun = 1'b0; mResync = 1'b0;
    memDue.delete(); memData.delete(); lastGrantAddr = -1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_memReq"}, mem_req, 0);
    checkOutput({tag, "_memAddr"}, mem_addr, 0);
    checkOutput({tag, "_rgb"}, rgbOut, 24'hFF00FF);
    checkOutput({tag, "_underrun"}, underrun, 0);
    checkOutput({tag, "_resync"}, resync, 0);
    checkOutput({tag, "_level"}, fifo_level, 0);
  endtask

  // One clock: present memory response, check request side, advance model, check outputs.
  task automatic tick();
    bit          presented, expReq, stepE, wrapE, emptyPre, rsp;
    mode_e       nextMode;
    logic [23:0] nextRgb;
    presented = 1'b0;
    if (!memHold && memDue.size() > 0 && memDue[0] <= cyc) begin
      mem_rvalid = 1'b1; mem_rdata = memData[0]; presented = 1'b1;
    end else begin
      mem_rvalid = 1'b0; mem_rdata = 16'h0000;
    end
    #2;
    expReq = (mMode == M_FETCH) && enable && (mFifo.size() + mOut < DEPTH) && (mOut < MAXOUT);
    checkOutput("memReq", mem_req, expReq);
    checkOutput("memAddr", mem_addr, mFetch);
    rsp = mem_rvalid && (mOut > 0);
    if (rsp && mMode != M_FLUSH)
      checkOutput("pushNotFull", 32'(fifo_level < DEPTH), 1);
    smpReq = mem_req; smpAddr = mem_addr;
    if (mem_req && mem_gnt) begin
      memDue.push_back(cyc + 2);
      memData.push_back(pixOf(int'(mem_addr)));
      grants++;
      if (lastGrantAddr == FRAME - 1) begin
        checkOutput("fetchWrap", mem_addr, 0);
        wrapSeen = 1'b1;
      end
      lastGrantAddr = int'(mem_addr);
    end

    stepE    = (int'(addr) != mPrevAddr) && (addr != 0);
    wrapE    = (addr == 0) && (mPrevAddr != 0);
    emptyPre = (mFifo.size() == 0);
    nextRgb  = (mMode != M_FLUSH && !emptyPre) ? expand(mFifo[0]) : 24'hFF00FF;
    nextMode = mMode;
    if (mMode == M_IDLE && enable) nextMode = M_FETCH;
    if (mMode == M_FETCH && !enable && mOut == 0) nextMode = M_IDLE;
    if (mMode == M_FLUSH && mOut == 0) nextMode = M_FETCH;
    mResync = 1'b0;
    if (expReq && mem_gnt) begin mFetch = (mFetch + 1) % FRAME; mOut++; end
    if (rsp) mOut--;
    if (stepE) begin
      mCons = (mCons + 1) % FRAME;
      if (!emptyPre) void'(mFifo.pop_front());
    end
    if (rsp && mMode != M_FLUSH) mFifo.push_back(mem_rdata);
    if (wrapE && mCons != 0) begin
      nextMode = M_FLUSH; mFifo.delete(); mCons = 0; mFetch = 0; mResync = 1'b1;
    end else if (stepE && emptyPre) begin
      nextMode = M_FLUSH; mFifo.delete(); mFetch = mCons; mUnderrun = 1'b1;
    end
    mMode = nextMode; mPrevAddr = int'(addr); mRgb = nextRgb;

    @(posedge clk_low);
    if (presented) begin void'(memDue.pop_front()); void'(memData.pop_front()); end
    cyc++;
    #1;
    checkOutput("rgb", rgbOut, mRgb);
    checkOutput("underrun", underrun, mUnderrun);
    checkOutput("resync", resync, mResync);
    checkOutput("fifoLevel", fifo_level, mFifo.size());
  endtask

  task automatic applyStimulus();
    bit found;
    int holdGrants;
    // Reset state and enable-to-request latency.
    reset = 1'b1; enable = 1'b0; addr = '0; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    memHold = 1'b0; cyc = 0; grants = 0; wrapSeen = 1'b0;
    modelReset();
    @(posedge clk_low); #1;
    checkResetValues("reset");
    reset = 1'b0;
    enable = 1'b1;
    tick();
    checkOutput("reqBeforeEnableSeen", smpReq, 0);
    tick();
    checkOutput("firstReq", smpReq, 1);
    checkOutput("firstReqAddr", smpAddr, 0);
    repeat (28) tick();
    checkOutput("pixel0Rgb", rgbOut, 24'hFF0000);
    checkOutput("fillLevel", fifo_level, 16);
    checkOutput("fillGrants", grants, 16);

    // Steps 0 -> 1 -> 2: each new pixel appears one cycle after its step.
    addr = 21'd1; tick();
    checkOutput("step1Latency", rgbOut, 24'hFF0000);
    tick();
    checkOutput("step1Rgb", rgbOut, 24'h00FF00);
    addr = 21'd2; tick(); tick();
    checkOutput("step2Rgb", rgbOut, 24'h0000FF);

    // Memory stall while the scan keeps stepping.
    mem_gnt = 1'b0;
    for (int i = 0; i < 40; i++) begin addr = addr + 21'd1; tick(); end
    checkOutput("stallUnderrun", underrun, 1);
    checkOutput("stallRgb", rgbOut, 24'hFF00FF);
    mem_gnt = 1'b1;
    repeat (30) tick();
    checkOutput("recoverRgb", rgbOut, expand(pixOf(int'(addr))));
    addr = addr + 21'd1; tick(); tick();
    checkOutput("recoverStepRgb", rgbOut, expand(pixOf(int'(addr))));

    // Early wrap after 1000 pixels is a frame slip.
    for (int a = int'(addr) + 1; a <= 1000; a++) begin addr = 21'(a); tick(); tick(); end
    addr = '0; tick();
    checkOutput("slipResync", resync, 1);
    tick();
    checkOutput("slipResyncPulse", resync, 0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin tick(); found = smpReq; end
    checkOutput("slipReqSeen", found, 1);
    checkOutput("slipReqAddr", smpAddr, 0);
    repeat (20) tick();
    checkOutput("slipPixel0", rgbOut, 24'hFF0000);

    // Full frame then wrap: no slip, fetch index wraps, frame 2 pixel 0 shown.
    for (int a = 1; a <= FRAME; a++) begin addr = 21'(a); tick(); tick(); end
    checkOutput("frame2Pixel0", rgbOut, 24'hFF0000);
    addr = '0; tick();
    checkOutput("frameNoResync", resync, 0);
    tick();
    checkOutput("frameWrapRgb", rgbOut, 24'hFF0000);
    checkOutput("fetchWrapSeen", wrapSeen, 1);

    // Reset with requests in flight and a partly drained FIFO.
    mem_gnt = 1'b0;
    repeat (4) tick();
    for (int a = 1; a <= 8; a++) begin addr = 21'(a); tick(); end
    memHold = 1'b1; mem_gnt = 1'b1; holdGrants = grants;
    repeat (5) tick();
    mem_gnt = 1'b0;
    checkOutput("heldGrants", grants - holdGrants, 5);
    #2; reset = 1'b1; #1;
    checkResetValues("midReset");
    modelReset();
    memHold = 1'b0; addr = '0; mem_gnt = 1'b1;
    @(posedge clk_low); #1;
    cyc++;
    reset = 1'b0;
    repeat (30) tick();
    checkOutput("postResetLevel", fifo_level, 16);
    checkOutput("postResetRgb", rgbOut, 24'hFF0000);
    checkOutput("postResetUnderrun", underrun, 0);
  endtask

  initial begin
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
